serial_subtractor_ctrl: RTL

//   Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first.

---
 rtl/serial_subtractor_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one 1-bit subtract cell sequenced over WIDTH bits,
// LSB first, with a start/done handshake and held diff/borrow_out outputs.

module serial_subtractor_hs (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);
   assign d  = x ^ y;
   assign bo = ~x & y;
endmodule

module serial_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);
   logic d1, b1, b2;

   serial_subtractor_hs u_hs0 (.x(a),  .y(b),  .d(d1), .bo(b1));
   serial_subtractor_hs u_hs1 (.x(d1), .y(bi), .d(d),  .bo(b2));

   assign bo = b1 | b2;
endmodule

module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa, sb, res;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             d_bit, br_nxt;

   serial_subtractor_cell u_cell (
      .a (sa[0]),
      .b (sb[0]),
      .bi(br),
      .d (d_bit),
      .bo(br_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         sa         <= '0;
         sb         <= '0;
         res        <= '0;
         cnt        <= '0;
         br         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               // result fills from the MSB end so it is aligned after WIDTH shifts
               res <= {d_bit, res[WIDTH-1:1]};
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               br  <= br_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  busy  <= 1'b0;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done       <= 1'b1;
               diff       <= res;
               borrow_out <= br;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
